diagonal_scan_ctrl: RTL and testbench
=====================================

// Module: diagonal_scan_ctrl
// PURPOSE
//  Sequencer for the diagonal X/Y walker datapath. Walks the upper triangle (x >= y) of a
//  (KMAX+1)x(KMAX+1) grid, one diagonal at a time, and issues each (x,y) to a downstream
//  consumer over a valid/ready handshake. Also drives the x>=y invariant flag for formal checks.
// PARAMETERS
//  W     4            coordinate width in bits
//  KMAX  (1<<W)-1     highest coordinate; fixed by W, not overridable
// PORTS
//  clk        in   1    single clock; all state updates on posedge
//  reset      in   1    synchronous, active-high
//  start      in   1    launch a scan; accepted only in IDLE
//  abort      in   1    terminate the scan at the next edge
//  out_ready  in   1    consumer can accept the current coordinate
//  out_valid  out  1    out_x/out_y/out_diag/out_last are valid
//  out_x      out  W    column coordinate
//  out_y      out  W    row coordinate
//  out_diag   out  W    diagonal index d = x - y
//  out_last   out  1    current beat is the final coordinate of the scan
//  beat_cnt   out  2W   accepted beats since the last start
//  busy       out  1    FSM is in RUN or DONE
//  done       out  1    1-cycle pulse after the last beat is accepted
//  prop       out  1    !(out_x < out_y); must be 1 every cycle
// BEHAVIOUR
//  - Reset: FSM=IDLE; out_valid=0, out_x=out_y=out_diag=0, out_last=0, beat_cnt=0, busy=0,
//    done=0, prop=1. Reset overrides every other input.
//  - States are IDLE, RUN and DONE.
//    IDLE -> RUN on start && !abort. Coordinates load to (x,y,d)=(0,0,0), beat_cnt clears,
//    and out_valid=1 on the next cycle (1-cycle latency).
//    RUN: a transfer is out_valid && out_ready. Outputs stay stable while out_valid && !out_ready.
//    RUN -> DONE when the beat with out_last is transferred.
//    DONE: done=1 and out_valid=0 for exactly one cycle; then DONE -> IDLE unconditionally.
//  - Step on transfer (no last beat):
//    if x==KMAX: d<=d+1, y<=0, x<=d+1
//    else:       x<=x+1, y<=y+1
//    Order: (0,0),(1,1)..(K,K),(1,0),(2,1)..(K,K-1),...,(K,0).
//  - out_last = (d==KMAX), which only occurs at (KMAX,0).
//  - No adder wraps: x+1 happens only for x<KMAX, and d+1 only for d<KMAX.
//  - Total beats = (KMAX+1)(KMAX+2)/2, i.e. 136 for W=4. beat_cnt is 2W bits wide and cannot overflow.
//  - beat_cnt increments on each transfer and holds after DONE until the next start.
//  - abort (any state) -> IDLE next cycle, out_valid=0, done is NOT pulsed, beat_cnt holds.
//    If abort coincides with a transfer, that beat counts (beat_cnt+1); no further beats follow.
//    If abort coincides with start in IDLE, abort wins and start is dropped.
//  - start while busy (RUN or DONE) is ignored and does not restart the scan.
//  - out_x/out_y/out_diag hold their last values in IDLE/DONE; out_last=0 whenever out_valid=0.
//  - prop is combinational from out_x/out_y. Any 0 on prop is a design error.
// STRUCTURE
//  - Package diag_scan_pkg:
//    state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), W, KMAX, BEAT_TOTAL.
//  - Sub-module diag_coord_step (combinational):
//    in x,y,d -> out nx,ny,nd,is_last; holds the step rule above.
//  - Top level holds the FSM, the coordinate/count registers and the handshake.
// TESTING
//  1 reset 2 cycles, idle -> out_valid=0, busy=0, done=0, beat_cnt=0, prop=1
//  2 start pulse, out_ready=1 always -> 136 beats: beat0 (0,0,d0), beat16 (1,0,d1),
//    beat135 (15,0,d15) with out_last=1; then done high 1 cycle; then busy=0, beat_cnt=136
//  3 out_ready toggled pseudo-randomly -> outputs stable while stalled, same 136-beat
//    order, no beat duplicated or dropped
//  4 abort on the cycle of the beat-20 transfer -> beat_cnt=21, IDLE next cycle, no done;
//    a new start restarts at (0,0) with beat_cnt=0
//  5 start asserted during RUN and in the DONE cycle -> ignored: order unbroken, one done
//    pulse; start+abort together in IDLE -> stays IDLE
//  6 reset asserted mid-scan with out_valid=1 and out_ready=0 -> all outputs at reset
//    values next cycle; prop=1 throughout all tests

Source files
------------

// File: rtl/diagonal_scan_ctrl_pkg.sv
// Shared constants and the FSM state encoding for the diagonal scan sequencer.
package diag_scan_pkg;

  localparam int W = 4;
  localparam logic [W-1:0] KMAX = '1;
  localparam int BEAT_TOTAL = ((1 << W) * ((1 << W) + 1)) / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/diagonal_scan_ctrl_if.sv
// Coordinate output channel of the diagonal scan sequencer.
// Handshake: a beat transfers on a clock edge where out_valid && out_ready; while
// out_valid is high and out_ready is low the producer holds every payload field stable.
interface diagonal_scan_ctrl_if;
  import diag_scan_pkg::*;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_x;
  logic [W-1:0] out_y;
  logic [W-1:0] out_diag;
  logic         out_last;

  modport master (
    output out_valid, out_x, out_y, out_diag, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_x, out_y, out_diag, out_last,
    output out_ready
  );

endinterface

// File: rtl/diagonal_scan_ctrl_coord_step.sv
// Next-coordinate rule for the upper-triangle walk: advance along the diagonal, or
// jump to the head of the next diagonal once the column reaches KMAX.
module diag_coord_step
  import diag_scan_pkg::*;
(
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] d,
  output logic [W-1:0] nx,
  output logic [W-1:0] ny,
  output logic [W-1:0] nd,
  output logic         is_last
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] d_inc;

  always_comb begin
    d_inc   = d + ONE;
    nx      = x;
    ny      = y;
    nd      = d;
    is_last = (d == KMAX);
    // The wrapped sums at x==KMAX or d==KMAX are never consumed by the caller.
    if (x == KMAX) begin
      nx = d_inc;
      ny = '0;
      nd = d_inc;
    end else begin
      nx = x + ONE;
      ny = y + ONE;
    end
  end

endmodule

// File: rtl/diagonal_scan_ctrl.sv
// Diagonal scan sequencer: walks the x >= y triangle one diagonal at a time and issues
// each coordinate over a valid/ready channel, with abort, beat counting and a done pulse.
module diagonal_scan_ctrl
  import diag_scan_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  diagonal_scan_ctrl_if.master out_if,
  output logic [2*W-1:0]       beat_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 prop,
  output state_e               state_o
);

  localparam logic [2*W-1:0] CNT_ONE = {{(2*W-1){1'b0}}, 1'b1};

  state_e         state_q;
  logic [W-1:0]   x_q, y_q, d_q;
  logic           valid_q;
  logic           last_q;
  logic           done_q;
  logic [2*W-1:0] cnt_q;

  logic [W-1:0]   x_d, y_d, d_d;
  logic           step_last;
  logic           xfer;

  diag_coord_step u_step (
    .x       (x_q),
    .y       (y_q),
    .d       (d_q),
    .nx      (x_d),
    .ny      (y_d),
    .nd      (d_d),
    .is_last (step_last)
  );

  assign xfer = valid_q && out_if.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      d_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q <= RUN;
            x_q     <= '0;
            y_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
          end
        end
        RUN: begin
          // A beat accepted on the abort edge still counts.
          if (xfer) cnt_q <= cnt_q + CNT_ONE;
          if (abort) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end else if (xfer) begin
            if (step_last) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              x_q    <= x_d;
              y_q    <= y_d;
              d_q    <= d_d;
              last_q <= (d_d == KMAX);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_x     = x_q;
  assign out_if.out_y     = y_q;
  assign out_if.out_diag  = d_q;
  assign out_if.out_last  = last_q;

  assign beat_cnt = cnt_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign prop     = !(x_q < y_q);
  assign state_o  = state_q;

endmodule

// File: tb/tb_diagonal_scan_ctrl.sv
// Bench for diagonal_scan_ctrl: directed scans feed an expected-coordinate queue that a
// negedge monitor drains on every accepted beat.
module tb_diagonal_scan_ctrl;
  import diag_scan_pkg::*;

  logic   clk;
  logic   reset;
  logic   start;
  logic   abort;
  logic [7:0] beat_cnt;
  logic   busy;
  logic   done;
  logic   prop;
  state_e state_dbg;

  diagonal_scan_ctrl_if bus ();

  diagonal_scan_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .out_if   (bus.master),
    .beat_cnt (beat_cnt),
    .busy     (busy),
    .done     (done),
    .prop     (prop),
    .state_o  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [12:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic        stalled_prev = 1'b0;
  logic [12:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Full scan order built diagonal by diagonal: d outer, y inner, x = y + d.
  task automatic push_scan();
    logic [3:0] xv, yv, dv;
    for (int d = 0; d <= 15; d++) begin
      for (int y = 0; y <= 15 - d; y++) begin
        xv = 4'(y + d);
        yv = 4'(y);
        dv = 4'(d);
        exp_q.push_back({xv, yv, dv, (d == 15)});
      end
    end
  endtask

  // monitor
  always @(negedge clk) begin
    logic [12:0] cur;
    logic [12:0] exp;
    cur = {bus.out_x, bus.out_y, bus.out_diag, bus.out_last};
    if (reset) begin
      stalled_prev = 1'b0;
    end else begin
      check("prop", 32'(prop), 32'd1);
      if (done) done_cnt++;
      if (bus.out_valid) begin
        if (stalled_prev) check("stable", 32'(cur), 32'(held));
        if (bus.out_ready) begin
          stalled_prev = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(cur), 32'h1fff);
          end else begin
            exp = exp_q.pop_front();
            check("beat", 32'(cur), 32'(exp));
          end
        end else begin
          stalled_prev = 1'b1;
          held = cur;
        end
      end else begin
        stalled_prev = 1'b0;
        if (bus.out_last) check("last_idle", 32'(bus.out_last), 32'd0);
      end
    end
  end

  // driver tasks
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int base);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != base) break;
    end
    check("done_seen", 32'(done_cnt - base), 32'd1);
  endtask

  task automatic check_end_of_scan(input int base);
    repeat (3) @(negedge clk);
    check("done_once", 32'(done_cnt - base), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
    check("valid_after", 32'(bus.out_valid), 32'd0);
    check("beat_cnt_total", 32'(beat_cnt), 32'(BEAT_TOTAL));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    bus.out_ready = 1'b1;

    // 1: reset state
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cnt", 32'(beat_cnt), 32'd0);
    check("rst_prop", 32'(prop), 32'd1);
    check("rst_state", 32'(state_dbg), 32'(IDLE));

    // 2: full scan with out_ready held high
    @(posedge clk); #1;
    push_scan();
    base = done_cnt;
    pulse_start();
    wait_done(400, base);
    check_end_of_scan(base);

    // 3: pseudo-random backpressure
    @(posedge clk); #1;
    push_scan();
    base = done_cnt;
    pulse_start();
    for (int i = 0; i < 3000; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (done_cnt != base) break;
    end
    bus.out_ready = 1'b1;
    check("bp_done_seen", 32'(done_cnt - base), 32'd1);
    check_end_of_scan(base);

    // 4: abort on the edge that accepts beat 20
    @(posedge clk); #1;
    push_scan();
    base = done_cnt;
    pulse_start();
    repeat (20) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cnt", 32'(beat_cnt), 32'd21);
    check("abort_state", 32'(state_dbg), 32'(IDLE));
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - base), 32'd0);
    check("abort_cnt_hold", 32'(beat_cnt), 32'd21);
    @(posedge clk); #1;
    push_scan();
    pulse_start();
    @(negedge clk);
    check("restart_cnt", 32'(beat_cnt), 32'd0);
    wait_done(400, base);
    check_end_of_scan(base);

    // 5: start during RUN and during DONE is ignored
    @(posedge clk); #1;
    push_scan();
    base = done_cnt;
    pulse_start();
    repeat (50) @(posedge clk);
    #1;
    pulse_start();
    repeat (85) @(posedge clk);
    #1;
    pulse_start();
    check_end_of_scan(base);
    check("idle_after_done_start", 32'(state_dbg), 32'(IDLE));
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_valid", 32'(bus.out_valid), 32'd0);
    check("start_abort_state", 32'(state_dbg), 32'(IDLE));

    // 6: reset mid-scan while stalled
    @(posedge clk); #1;
    push_scan();
    pulse_start();
    repeat (10) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_q.delete();
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_xy", 32'({bus.out_x, bus.out_y, bus.out_diag}), 32'd0);
    check("mid_rst_last", 32'(bus.out_last), 32'd0);
    check("mid_rst_cnt", 32'(beat_cnt), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_prop", 32'(prop), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
